// File: rtl/lookup_pkg.sv
// ----------------------------------------------------------------------------
// lookup_pkg
// Shared definitions for the key lookup CAM stage:
//   - bit offsets of the in-band control header fields within the 512b beat
//   - control header magic flag and resv command codes
//   - control-path FSM state encoding
// No ports (package).
// ----------------------------------------------------------------------------
package lookup_pkg;

    // Control header field offsets (LSB position within tdata)
    localparam int FLAG_OFS   = 320;   // 16 bits
    localparam int MOD_ID_OFS = 368;   // 8 bits: {stage[4:0], lookup[2:0]}
    localparam int RESV_OFS   = 376;   // 4 bits: command code
    localparam int INDEX_OFS  = 384;   // 8 bits: first entry to write

    localparam logic [15:0] CTRL_FLAG = 16'hf2f1;

    // resv command codes
    localparam logic [3:0] RESV_KEY = 4'h0;   // CAM key write
    localparam logic [3:0] RESV_ACT = 4'h1;   // nominal action write (any non-zero)
    localparam logic [3:0] RESV_DEF = 4'hF;   // default action write (when enabled)

    // Control FSM. SU_* states are the "subsequent beat" variants: the write
    // pointer has already been bumped past the header's index.
    typedef enum logic [2:0] {
        IDLE_C         = 3'd0,
        WRITE_KEY_C    = 3'd1,
        SU_WRITE_KEY_C = 3'd2,
        WRITE_ACT_C    = 3'd3,
        SU_WRITE_ACT_C = 3'd4,
        WRITE_DEF_C    = 3'd5
    } ctrl_state_e;

endpackage

// File: rtl/cam_match_prio.sv
// ----------------------------------------------------------------------------
// cam_match_prio
// Purely combinational CAM search: compares a key against every entry and
// returns the lowest-index matching entry.
// Ports:
//   key          in  KEY_LEN              search key
//   entry_keys   in  CAM_DEPTH*KEY_LEN    all entry keys, entry i at [i*KEY_LEN +: KEY_LEN]
//   entry_valid  in  CAM_DEPTH            per-entry valid bit
//   hit          out 1                    at least one entry matched
//   idx          out IDX_W                lowest matching index (0 when no hit)
// ----------------------------------------------------------------------------
module cam_match_prio #(
    parameter int KEY_LEN   = 193,
    parameter int CAM_DEPTH = 16,
    parameter int IDX_W     = 4
) (
    input  logic [KEY_LEN-1:0]           key,
    input  logic [CAM_DEPTH*KEY_LEN-1:0] entry_keys,
    input  logic [CAM_DEPTH-1:0]         entry_valid,
    output logic                         hit,
    output logic [IDX_W-1:0]             idx
);

    logic [CAM_DEPTH-1:0] match;

    genvar gi;
    generate
        for (gi = 0; gi < CAM_DEPTH; gi++) begin : g_cmp
            assign match[gi] = entry_valid[gi] &
                               (entry_keys[gi*KEY_LEN +: KEY_LEN] == key);
        end
    endgenerate

    // Scan from the top down so the lowest matching index is the last one
    // assigned and therefore wins.
    always_comb begin
        idx = '0;
        for (int i = CAM_DEPTH - 1; i >= 0; i--) begin
            if (match[i]) begin
                idx = IDX_W'(i);
            end
        end
        hit = |match;
    end

endmodule

// File: rtl/key_lookup_cam.sv
// ----------------------------------------------------------------------------
// key_lookup_cam
// Match stage after key extraction. Each accepted PHV+key goes through a
// 3-stage pipeline (register, CAM compare, action RAM read) and comes out
// with the action word of the lowest matching CAM entry. CAM keys and actions
// are loaded in-band on the control stream; other control beats are
// forwarded with one register of delay.
//
// Optional feature macro: LOOKUP_DEFAULT_ACT_EN
//   defined   : control resv==4'hF loads a default action used on a miss
//   undefined : a miss outputs an all-zero action; resv==4'hF is an action write
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   phv_in/phv_valid_in           PHV from key extract
//   key_in/key_valid_in           masked key (valid together with PHV)
//   ready_out                     stage can accept this cycle
//   phv_out/phv_valid_out         delayed PHV
//   action_out/hit_out            action of matched entry / match flag
//   ready_in                      downstream ready
//   c_s_axis_t*                   control stream in
//   c_m_axis_t*                   control stream out (registered)
// ----------------------------------------------------------------------------
module key_lookup_cam
    import lookup_pkg::*;
#(
    parameter int C_S_AXIS_DATA_WIDTH  = 512,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int STAGE_ID             = 0,
    parameter int LOOKUP_ID            = 2,
    parameter int PHV_LEN              = 1024,
    parameter int KEY_LEN              = 193,
    parameter int ACT_LEN              = 625,
    parameter int CAM_DEPTH            = 16
) (
    input  logic                                 clk,
    input  logic                                 rst,

    input  logic [PHV_LEN-1:0]                   phv_in,
    input  logic                                 phv_valid_in,
    input  logic [KEY_LEN-1:0]                   key_in,
    input  logic                                 key_valid_in,
    output logic                                 ready_out,

    output logic [PHV_LEN-1:0]                   phv_out,
    output logic                                 phv_valid_out,
    output logic [ACT_LEN-1:0]                   action_out,
    output logic                                 hit_out,
    input  logic                                 ready_in,

    input  logic [C_S_AXIS_DATA_WIDTH-1:0]       c_s_axis_tdata,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]      c_s_axis_tuser,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]     c_s_axis_tkeep,
    input  logic                                 c_s_axis_tvalid,
    input  logic                                 c_s_axis_tlast,

    output logic [C_S_AXIS_DATA_WIDTH-1:0]       c_m_axis_tdata,
    output logic [C_S_AXIS_TUSER_WIDTH-1:0]      c_m_axis_tuser,
    output logic [C_S_AXIS_DATA_WIDTH/8-1:0]     c_m_axis_tkeep,
    output logic                                 c_m_axis_tvalid,
    output logic                                 c_m_axis_tlast
);

    localparam int DATA_W = C_S_AXIS_DATA_WIDTH;
    localparam int NBYTES = DATA_W / 8;
    localparam int IDX_W  = (CAM_DEPTH > 1) ? $clog2(CAM_DEPTH) : 1;

    // ------------------------------------------------------------------
    // Control path decode
    // ------------------------------------------------------------------
    ctrl_state_e             state_reg;
    logic [7:0]              wptr_reg;      // 8-bit so it wraps like the header index
    logic [DATA_W-1:0]       swapped;
    logic [7:0]              mod_id;
    logic [3:0]              resv;
    logic [15:0]             flag;
    logic [7:0]              index;
    logic                    is_hdr;
    logic                    in_range;
    logic [IDX_W-1:0]        waddr;
    logic                    key_we;
    logic                    act_we;
    logic [KEY_LEN:0]        key_wdata;     // {valid, key}
    logic [ACT_LEN-1:0]      act_wdata;
    logic [ACT_LEN-1:0]      def_act;

    // Payload beats arrive byte-reversed relative to the entry layout.
    genvar gi;
    generate
        for (gi = 0; gi < NBYTES; gi++) begin : g_swap
            assign swapped[gi*8 +: 8] = c_s_axis_tdata[(NBYTES-1-gi)*8 +: 8];
        end
    endgenerate

    assign mod_id   = c_s_axis_tdata[MOD_ID_OFS +: 8];
    assign resv     = c_s_axis_tdata[RESV_OFS +: 4];
    assign flag     = c_s_axis_tdata[FLAG_OFS +: 16];
    assign index    = c_s_axis_tdata[INDEX_OFS +: 8];
    assign is_hdr   = c_s_axis_tvalid &
                      (mod_id == {5'(STAGE_ID), 3'(LOOKUP_ID)}) &
                      (flag == CTRL_FLAG);

    // Indices past the table are silently dropped rather than aliased.
    assign in_range = 32'(wptr_reg) < CAM_DEPTH;
    assign waddr    = wptr_reg[IDX_W-1:0];

    assign key_wdata = swapped[DATA_W-1 -: KEY_LEN+1];

    // The action may be wider than one beat: the beat fills the top bits and
    // the remainder is zero.
    generate
        if (ACT_LEN > DATA_W) begin : g_act_pad
            assign act_wdata = {swapped, {(ACT_LEN-DATA_W){1'b0}}};
        end else begin : g_act_cut
            assign act_wdata = swapped[DATA_W-1 -: ACT_LEN];
        end
    endgenerate

    assign key_we = ~rst & c_s_axis_tvalid & in_range &
                    ((state_reg == WRITE_KEY_C) | (state_reg == SU_WRITE_KEY_C));
    assign act_we = ~rst & c_s_axis_tvalid & in_range &
                    ((state_reg == WRITE_ACT_C) | (state_reg == SU_WRITE_ACT_C));

`ifdef LOOKUP_DEFAULT_ACT_EN
    logic                def_we;
    logic [ACT_LEN-1:0]  def_act_reg;

    assign def_we = ~rst & c_s_axis_tvalid & (state_reg == WRITE_DEF_C);

    always_ff @(posedge clk) begin
        if (rst) begin
            def_act_reg <= '0;
        end else if (def_we) begin
            def_act_reg <= act_wdata;
        end
    end
    assign def_act = def_act_reg;
`else
    assign def_act = '0;
`endif

    // ------------------------------------------------------------------
    // Control FSM: consumes our packets, forwards everything else
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= IDLE_C;
            wptr_reg        <= '0;
            c_m_axis_tdata  <= '0;
            c_m_axis_tuser  <= '0;
            c_m_axis_tkeep  <= '0;
            c_m_axis_tvalid <= 1'b0;
            c_m_axis_tlast  <= 1'b0;
        end else begin
            // Consumed beats leave an idle slot on the output.
            c_m_axis_tdata  <= '0;
            c_m_axis_tuser  <= '0;
            c_m_axis_tkeep  <= '0;
            c_m_axis_tvalid <= 1'b0;
            c_m_axis_tlast  <= 1'b0;
            case (state_reg)
                IDLE_C: begin
                    if (is_hdr) begin
                        wptr_reg <= index;
                        if (c_s_axis_tlast) begin
                            state_reg <= IDLE_C;
                        end else if (resv == RESV_KEY) begin
                            state_reg <= WRITE_KEY_C;
`ifdef LOOKUP_DEFAULT_ACT_EN
                        end else if (resv == RESV_DEF) begin
                            state_reg <= WRITE_DEF_C;
`endif
                        end else begin
                            state_reg <= WRITE_ACT_C;
                        end
                    end else begin
                        c_m_axis_tdata  <= c_s_axis_tdata;
                        c_m_axis_tuser  <= c_s_axis_tuser;
                        c_m_axis_tkeep  <= c_s_axis_tkeep;
                        c_m_axis_tvalid <= c_s_axis_tvalid;
                        c_m_axis_tlast  <= c_s_axis_tlast;
                    end
                end
                WRITE_KEY_C, SU_WRITE_KEY_C: begin
                    if (c_s_axis_tvalid) begin
                        wptr_reg  <= wptr_reg + 8'd1;
                        state_reg <= c_s_axis_tlast ? IDLE_C : SU_WRITE_KEY_C;
                    end
                end
                WRITE_ACT_C, SU_WRITE_ACT_C: begin
                    if (c_s_axis_tvalid) begin
                        wptr_reg  <= wptr_reg + 8'd1;
                        state_reg <= c_s_axis_tlast ? IDLE_C : SU_WRITE_ACT_C;
                    end
                end
                WRITE_DEF_C: begin
                    if (c_s_axis_tvalid && c_s_axis_tlast) begin
                        state_reg <= IDLE_C;
                    end
                end
                default: state_reg <= IDLE_C;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // CAM entry storage (flip-flops, searched in parallel)
    // ------------------------------------------------------------------
    logic [KEY_LEN-1:0]           cam_key_reg [CAM_DEPTH];
    logic                         cam_vld_reg [CAM_DEPTH];
    logic [CAM_DEPTH*KEY_LEN-1:0] entry_keys;
    logic [CAM_DEPTH-1:0]         entry_valid;

    generate
        for (gi = 0; gi < CAM_DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (rst) begin
                    cam_vld_reg[gi] <= 1'b0;
                end else if (key_we && (waddr == IDX_W'(gi))) begin
                    cam_vld_reg[gi] <= key_wdata[KEY_LEN];
                end
            end
            always_ff @(posedge clk) begin
                if (key_we && (waddr == IDX_W'(gi))) begin
                    cam_key_reg[gi] <= key_wdata[KEY_LEN-1:0];
                end
            end
            assign entry_keys[gi*KEY_LEN +: KEY_LEN] = cam_key_reg[gi];
            assign entry_valid[gi]                   = cam_vld_reg[gi];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Lookup pipeline
    // ------------------------------------------------------------------
    logic                advance;
    logic                accept;
    logic                s1_valid_reg;
    logic [PHV_LEN-1:0]  s1_phv_reg;
    logic [KEY_LEN-1:0]  s1_key_reg;
    logic                s2_valid_reg;
    logic [PHV_LEN-1:0]  s2_phv_reg;
    logic                s2_hit_reg;
    logic [IDX_W-1:0]    s2_idx_reg;
    logic                match_hit;
    logic [IDX_W-1:0]    match_idx;
    logic [ACT_LEN-1:0]  act_rd_reg;
    logic [ACT_LEN-1:0]  miss_act_reg;

    // Whole pipeline moves as one; a stall freezes every stage in place.
    assign advance   = ~phv_valid_out | ready_in;
    assign ready_out = advance;
    assign accept    = phv_valid_in & key_valid_in & advance;

    cam_match_prio #(
        .KEY_LEN   (KEY_LEN),
        .CAM_DEPTH (CAM_DEPTH),
        .IDX_W     (IDX_W)
    ) u_match (
        .key         (s1_key_reg),
        .entry_keys  (entry_keys),
        .entry_valid (entry_valid),
        .hit         (match_hit),
        .idx         (match_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_reg  <= 1'b0;
            s2_valid_reg  <= 1'b0;
            s2_hit_reg    <= 1'b0;
            s2_idx_reg    <= '0;
            phv_valid_out <= 1'b0;
            phv_out       <= '0;
            hit_out       <= 1'b0;
            miss_act_reg  <= '0;
        end else if (advance) begin
            s1_valid_reg  <= accept;
            s1_phv_reg    <= phv_in;
            s1_key_reg    <= key_in;
            s2_valid_reg  <= s1_valid_reg;
            s2_phv_reg    <= s1_phv_reg;
            s2_hit_reg    <= match_hit;
            s2_idx_reg    <= match_idx;
            phv_valid_out <= s2_valid_reg;
            phv_out       <= s2_phv_reg;
            hit_out       <= s2_valid_reg & s2_hit_reg;
            // Snapshot so a default-action update cannot change a held output.
            miss_act_reg  <= def_act;
        end
    end

    // Action RAM: registered read-first port, so a same-cycle write to the
    // entry being read returns the old word.
    logic [ACT_LEN-1:0] act_ram [CAM_DEPTH];

    always_ff @(posedge clk) begin
        if (act_we) begin
            act_ram[waddr] <= act_wdata;
        end
        if (advance) begin
            act_rd_reg <= act_ram[s2_idx_reg];
        end
    end

    assign action_out = hit_out ? act_rd_reg : miss_act_reg;

endmodule
